// File: rtl/muldiv_if.sv
// Handshake and operand bundle between execute-stage control and the RV32M
// multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, funct3, a, b, input busy, done, result);
  modport slave  (input start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up on the last step.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state, w_state_next;
  logic [4:0]       r_count;
  logic [2:0]       r_op;
  logic             r_neg;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd, r_result;

  logic             w_accept, w_a_signed, w_b_signed, w_sa, w_sb;
  logic             w_div_zero, w_div_ovf, w_special, w_neg, w_last;
  logic             w_busy, w_done;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_special_res;

  // Launch-time decode, taken straight from the interface inputs
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign w_b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_sa       = w_a_signed & bus.a[WIDTH-1];
  assign w_sb       = w_b_signed & bus.b[WIDTH-1];
  assign w_mag_a    = w_sa ? -bus.a : bus.a;
  assign w_mag_b    = w_sb ? -bus.b : bus.b;
  // Remainder follows the dividend; product and quotient follow the sign XOR
  assign w_neg      = (bus.funct3[2] & bus.funct3[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_div_zero = bus.funct3[2] && (bus.b == '0);
  assign w_div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.a == MIN_INT) && (bus.b == '1);
  assign w_special  = w_div_zero || w_div_ovf;
  assign w_special_res = w_div_zero ? (bus.funct3[1] ? bus.a : '1)
                                    : (bus.funct3[1] ? '0 : MIN_INT);
  assign w_last     = (r_count == 5'd31);

  // Multiply step: {hi,lo} holds partial product over the remaining multiplier bits
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_prod;
  logic [WIDTH-1:0]   w_mul_res;
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};
  assign w_prod     = r_neg ? -w_mul_next : w_mul_next;
  assign w_mul_res  = (r_op == 3'd0) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

  // Divide step: hi is the partial remainder, lo shifts dividend out / quotient in
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_div_hi, w_div_lo, w_div_res;
  assign w_trial   = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_opnd};
  assign w_fits    = ~w_trial[WIDTH];
  assign w_div_hi  = w_fits ? w_trial[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_div_lo  = {r_lo[WIDTH-2:0], w_fits};
  assign w_div_res = r_op[1] ? (r_neg ? -w_div_hi : w_div_hi)
                             : (r_neg ? -w_div_lo : w_div_lo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept) begin
          if (w_special)          w_state_next = S_DONE;
          else if (bus.funct3[2]) w_state_next = S_DIV;
          else                    w_state_next = S_MUL;
        end
      end
      S_MUL, S_DIV: if (w_last) w_state_next = S_DONE;
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= bus.funct3;
          r_neg   <= w_neg;
          r_count <= '0;
          r_hi    <= '0;
          r_lo    <= bus.funct3[2] ? w_mag_a : w_mag_b;
          r_opnd  <= bus.funct3[2] ? w_mag_b : w_mag_a;
          if (w_special) r_result <= w_special_res;
        end
        S_MUL: begin
          {r_hi, r_lo} <= w_mul_next;
          r_count      <= r_count + 5'd1;
          if (w_last) r_result <= w_mul_res;
        end
        S_DIV: begin
          r_hi    <= w_div_hi;
          r_lo    <= w_div_lo;
          r_count <= r_count + 5'd1;
          if (w_last) r_result <= w_div_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, busy window,
// special-case divides, ignored restart and asynchronous abort.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.funct3 = ~f;
    bus.a      = $urandom;
    bus.b      = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    int busy_cyc;
    bit seen;
    cyc = 0; busy_cyc = 0; seen = 0;
    launch(f, a, b);
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) seen = 1;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " busy cycles"}, 32'(busy_cyc), 32'(lat));
    check({tag, " result"}, bus.result, exp);
    @(negedge clk);
    check({tag, " done low after"}, {31'd0, bus.done}, 32'd0);
    check({tag, " result held"}, bus.result, exp);
  endtask

  initial begin
    int cyc;
    int ndone;
    int first_done;
    logic [31:0] res;

    bus.start = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("MUL 7*-3",          3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("MULH min*min",      3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("MULHU 2^31*2^31",   3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("MULHSU -1*ffff",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("DIV -7/2",          3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("REM -7/2",          3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("DIVU 100/7",        3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_op("REMU 100/7",        3'd7, 32'd100,      32'd7,        32'd2,        33);
    run_op("DIVU by zero",      3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 1);
    run_op("REMU by zero",      3'd7, 32'h1234,     32'd0,        32'h00001234, 1);
    run_op("DIV overflow",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM overflow",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Restart pulse while busy must be ignored
    launch(3'd0, 32'd5, 32'd6);
    cyc = 0; ndone = 0; first_done = 0; res = '0;
    while (cyc < 45) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.a = 32'd100; bus.b = 32'd3;
      end
      if (cyc == 6) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          first_done = cyc;
          res = bus.result;
        end
      end
    end
    check("restart done count", 32'(ndone), 32'd1);
    check("restart latency", 32'(first_done), 32'd33);
    check("restart result", res, 32'd30);

    // Asynchronous abort mid-operation
    launch(3'd0, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort result", bus.result, 32'd0);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    check("held in reset idle", 32'(ndone), 32'd0);
    rst = 1'b1;
    run_op("MUL 3*4 after reset", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
